// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: turns resolved control-flow results into a fetch redirect,
// a squash window, predictor update traffic and a saturating mispredict count.
module branch_resolve_unit #(
    parameter int SIZE_PC      = 32,
    parameter int UPD_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               exeValid_i,
    input  logic [SIZE_PC-1:0] pc_i,
    input  logic [SIZE_PC-1:0] nextPC_i,
    input  logic               direction_i,
    input  logic [7:0]         flags_i,
    output logic               exeStall_o,
    output logic               recoverFlag_o,
    output logic [SIZE_PC-1:0] recoverPC_o,
    output logic               squash_o,
    output logic               updValid_o,
    output logic [SIZE_PC-1:0] updPC_o,
    output logic [SIZE_PC-1:0] updTarget_o,
    output logic               updDir_o,
    output logic               updMispredict_o,
    input  logic               updReady_i,
    output logic [15:0]        mispredictCount_o
);
    localparam int AW = $clog2(UPD_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef struct packed {
        logic [SIZE_PC-1:0] pc;
        logic [SIZE_PC-1:0] target;
        logic               dir;
        logic               mispred;
    } upd_entry_t;

    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} rec_state_t;

    upd_entry_t         mem [UPD_DEPTH];
    upd_entry_t         head;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic               empty, full, accept, pop, mispred_acc;
    rec_state_t         state, state_n;
    logic [CW-1:0]      flush_cnt, flush_cnt_n;
    logic [SIZE_PC-1:0] redir_pc;
    logic [15:0]        mispredict_cnt;
    logic               unused_flags;

    assign unused_flags = ^{flags_i[7:6], flags_i[4:1]};

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign accept      = exeValid_i & flags_i[5] & ~squash_o & ~full;
    assign mispred_acc = accept & flags_i[0];
    assign pop         = ~empty & updReady_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < UPD_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr[AW-1:0]] <= '{pc: pc_i, target: nextPC_i,
                                          dir: direction_i, mispred: flags_i[0]};
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    assign head            = mem[rd_ptr[AW-1:0]];
    assign updValid_o      = ~empty;
    assign updPC_o         = head.pc;
    assign updTarget_o     = head.target;
    assign updDir_o        = head.dir;
    assign updMispredict_o = head.mispred;
    assign exeStall_o      = full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            flush_cnt <= '0;
            redir_pc  <= '0;
        end else begin
            state     <= state_n;
            flush_cnt <= flush_cnt_n;
            if (mispred_acc) redir_pc <= nextPC_i;
        end
    end

    always_comb begin
        state_n     = state;
        flush_cnt_n = flush_cnt;
        case (state)
            IDLE:     if (mispred_acc) state_n = REDIRECT;
            REDIRECT: begin
                state_n     = DRAIN;
                flush_cnt_n = CW'(FLUSH_CYCLES);
            end
            DRAIN: begin
                flush_cnt_n = flush_cnt - CW'(1);
                if (flush_cnt == CW'(1)) state_n = IDLE;
            end
            default:  state_n = IDLE;
        endcase
    end

    assign squash_o      = (state != IDLE);
    assign recoverFlag_o = (state == REDIRECT);
    assign recoverPC_o   = recoverFlag_o ? redir_pc : '0;

    always_ff @(posedge clk) begin
        if (reset)                                     mispredict_cnt <= '0;
        else if (mispred_acc && mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
    end

    assign mispredictCount_o = mispredict_cnt;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed expectations checked after each edge.
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        exeValid_i;
    logic [31:0] pc_i, nextPC_i;
    logic        direction_i;
    logic [7:0]  flags_i;
    logic        exeStall_o, recoverFlag_o, squash_o, updValid_o, updDir_o, updMispredict_o;
    logic [31:0] recoverPC_o, updPC_o, updTarget_o;
    logic        updReady_i;
    logic [15:0] mispredictCount_o;

    int compared   = 0;
    int mismatched = 0;

    branch_resolve_unit #(.SIZE_PC(32), .UPD_DEPTH(4), .FLUSH_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .exeValid_i(exeValid_i), .pc_i(pc_i), .nextPC_i(nextPC_i),
        .direction_i(direction_i), .flags_i(flags_i), .exeStall_o(exeStall_o),
        .recoverFlag_o(recoverFlag_o), .recoverPC_o(recoverPC_o), .squash_o(squash_o),
        .updValid_o(updValid_o), .updPC_o(updPC_o), .updTarget_o(updTarget_o),
        .updDir_o(updDir_o), .updMispredict_o(updMispredict_o), .updReady_i(updReady_i),
        .mispredictCount_o(mispredictCount_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge, outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] npc,
                           input logic dir, input logic [7:0] fl);
        exeValid_i = 1'b1; pc_i = pc; nextPC_i = npc; direction_i = dir; flags_i = fl;
    endtask

    task automatic idle();
        exeValid_i = 1'b0; pc_i = '0; nextPC_i = '0; direction_i = 1'b0; flags_i = '0;
    endtask

    initial begin
        idle();
        updReady_i = 1'b1;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_recflag", recoverFlag_o, 0);
        chk("rst_recpc",   recoverPC_o, 0);
        chk("rst_squash",  squash_o, 0);
        chk("rst_valid",   updValid_o, 0);
        chk("rst_updpc",   updPC_o, 0);
        chk("rst_updtgt",  updTarget_o, 0);
        chk("rst_upddir",  updDir_o, 0);
        chk("rst_updmis",  updMispredict_o, 0);
        chk("rst_stall",   exeStall_o, 0);
        chk("rst_count",   mispredictCount_o, 0);

        // Three correctly predicted branches, predictor always ready
        present(32'h100, 32'h104, 1'b0, 8'h24); tick();
        chk("ok0_valid", updValid_o, 1); chk("ok0_pc", updPC_o, 32'h100);
        chk("ok0_recflag", recoverFlag_o, 0);
        present(32'h108, 32'h10c, 1'b0, 8'h24); tick();
        chk("ok1_pc", updPC_o, 32'h108); chk("ok1_tgt", updTarget_o, 32'h10c);
        present(32'h110, 32'h200, 1'b1, 8'h24); tick();
        chk("ok2_pc", updPC_o, 32'h110); chk("ok2_tgt", updTarget_o, 32'h200);
        chk("ok2_dir", updDir_o, 1); chk("ok2_mis", updMispredict_o, 0);
        idle(); tick();
        chk("ok_empty", updValid_o, 0); chk("ok_count", mispredictCount_o, 0);

        // Mispredict, then a result presented during redirect must be ignored
        present(32'h200, 32'h340, 1'b1, 8'h25); tick();
        chk("mp_recflag", recoverFlag_o, 1); chk("mp_recpc", recoverPC_o, 32'h340);
        chk("mp_squash", squash_o, 1); chk("mp_count", mispredictCount_o, 1);
        chk("mp_valid", updValid_o, 1); chk("mp_updpc", updPC_o, 32'h200);
        chk("mp_updmis", updMispredict_o, 1);
        present(32'h300, 32'h304, 1'b0, 8'h24); tick();
        idle();
        chk("mp_recflag_off", recoverFlag_o, 0); chk("mp_sq2", squash_o, 1);
        chk("mp_ignored", updValid_o, 0);
        tick(); chk("mp_sq3", squash_o, 1);
        tick(); chk("mp_sq4", squash_o, 1);
        tick(); chk("mp_sq_end", squash_o, 0); chk("mp_still_empty", updValid_o, 0);

        // Fill the FIFO with the predictor stalled
        updReady_i = 1'b0;
        present(32'h400, 32'h410, 1'b0, 8'h24); tick();
        present(32'h404, 32'h414, 1'b1, 8'h24); tick();
        present(32'h408, 32'h418, 1'b0, 8'h24); tick();
        chk("fill3_stall", exeStall_o, 0);
        present(32'h40c, 32'h41c, 1'b1, 8'h24); tick();
        chk("fill4_stall", exeStall_o, 1); chk("fill4_head", updPC_o, 32'h400);
        present(32'h410, 32'h420, 1'b0, 8'h24); tick();
        idle();
        chk("fill5_stall", exeStall_o, 1); chk("fill5_head", updPC_o, 32'h400);
        updReady_i = 1'b1; tick();
        chk("drain1_stall", exeStall_o, 0); chk("drain1_pc", updPC_o, 32'h404);
        chk("drain1_dir", updDir_o, 1);
        tick(); chk("drain2_pc", updPC_o, 32'h408);
        tick(); chk("drain3_pc", updPC_o, 32'h40c); chk("drain3_tgt", updTarget_o, 32'h41c);
        tick(); chk("drain_empty", updValid_o, 0);

        // Push and pop together at count 2
        updReady_i = 1'b0;
        present(32'h500, 32'h510, 1'b0, 8'h24); tick();
        present(32'h504, 32'h514, 1'b0, 8'h24); tick();
        updReady_i = 1'b1;
        present(32'h508, 32'h518, 1'b1, 8'h24); tick();
        idle();
        chk("pp_head", updPC_o, 32'h504); chk("pp_stall", exeStall_o, 0);
        tick(); chk("pp_next", updPC_o, 32'h508);
        tick(); chk("pp_empty", updValid_o, 0);

        // Streaming transfers to wrap the pointers several times
        for (int i = 0; i < 9; i++) begin
            present(32'h600 + 32'(4 * i), 32'h700 + 32'(4 * i), 1'(i), 8'h24); tick();
            chk("wrap_valid", updValid_o, 1);
            chk("wrap_pc",    updPC_o, 32'h600 + 32'(4 * i));
            chk("wrap_tgt",   updTarget_o, 32'h700 + 32'(4 * i));
        end
        idle(); tick();
        chk("wrap_empty", updValid_o, 0);

        // Reset during DRAIN with two entries queued
        updReady_i = 1'b0;
        present(32'h800, 32'h804, 1'b0, 8'h24); tick();
        present(32'h808, 32'h900, 1'b1, 8'h25); tick();
        idle();
        chk("rd_redirect", recoverFlag_o, 1);
        tick();
        chk("rd_drain", squash_o, 1); chk("rd_count2", mispredictCount_o, 2);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rd_squash", squash_o, 0); chk("rd_valid", updValid_o, 0);
        chk("rd_count", mispredictCount_o, 0); chk("rd_stall", exeStall_o, 0);
        updReady_i = 1'b1;
        present(32'hA00, 32'hA04, 1'b0, 8'h24); tick();
        idle();
        chk("rd_accept_valid", updValid_o, 1); chk("rd_accept_pc", updPC_o, 32'hA00);
        tick();

        // Saturation of the mispredict counter
        force dut.mispredict_cnt = 16'hFFFE;
        #1;
        release dut.mispredict_cnt;
        chk("sat_forced", mispredictCount_o, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            present(32'hB00 + 32'(16 * k), 32'hB40, 1'b1, 8'h25); tick();
            idle();
            chk("sat_count", mispredictCount_o, 16'hFFFF);
            repeat (5) tick();
        end
        chk("sat_hold", mispredictCount_o, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
